eq_band_sched: RTL and testbench

Scheduler between the I2S deserializer and the shared band-filter engine of the audio equalizer. Each valid stereo sample is issued to the single shared filter engine as one job per (band, channel), one job in flight at a time. The block sums the per-band results per channel, saturates them to 24 bits and presents the equalized stereo sample downstream. A one-deep pending buffer absorbs a sample that arrives while a frame is still being processed; loss beyond that is flagged.

---
 rtl/eq_pkg.sv | 23 ++
 rtl/eq_sat_acc.sv | 32 +++
 rtl/eq_band_sched.sv | 150 +++++++++++++++
 tb/tb_eq_band_sched.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared types and constants for the equalizer band scheduler.
package eq_pkg;

  localparam int SMPL_W = 24;
  localparam int ACC_W  = 27;

  localparam logic [SMPL_W-1:0] SMPL_MAX = 24'h7F_FFFF;
  localparam logic [SMPL_W-1:0] SMPL_MIN = 24'h80_0000;

  // Same limits expressed at accumulator width for signed comparison.
  localparam logic signed [ACC_W-1:0] ACC_HI = 27'sd8388607;
  localparam logic signed [ACC_W-1:0] ACC_LO = -27'sd8388608;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} sched_state_t;

  // Clamp a wide accumulator to the signed 24-bit sample range.
  function automatic logic [SMPL_W-1:0] sat_smpl(input logic signed [ACC_W-1:0] a);
    if (a > ACC_HI)      return SMPL_MAX;
    else if (a < ACC_LO) return SMPL_MIN;
    else                 return a[SMPL_W-1:0];
  endfunction

endpackage

// File: rtl/eq_sat_acc.sv
// One channel accumulator: sign-extended adds of band results, with clear.
// sat_o is the saturated value the accumulator holds after this cycle, so the
// top can capture the final sum on the same edge the last result is added.
module eq_sat_acc
  import eq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [SMPL_W-1:0] din_i,
  output logic [SMPL_W-1:0] sat_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d;

  // Next accumulator value: clear has priority over add.
  always_comb begin
    acc_d = acc_q;
    if (clr_i)      acc_d = '0;
    else if (add_i) acc_d = acc_q + {{(ACC_W-SMPL_W){din_i[SMPL_W-1]}}, din_i};
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign sat_o = sat_smpl(acc_d);

endmodule

// File: rtl/eq_band_sched.sv
// Issues one filter job per (band, channel) for each stereo sample, sums the
// results per channel and presents the saturated stereo result downstream.
module eq_band_sched
  import eq_pkg::*;
#(
  parameter int NUM_BANDS = 5,
  parameter int BAND_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              smpl_vld,
  input  logic [SMPL_W-1:0] smpl_lft,
  input  logic [SMPL_W-1:0] smpl_rght,
  output logic              job_req,
  input  logic              job_ack,
  output logic [BAND_W-1:0] job_band,
  output logic              job_chnl,
  output logic [SMPL_W-1:0] job_smpl,
  input  logic              res_vld,
  input  logic [SMPL_W-1:0] res_data,
  output logic              out_vld,
  output logic [SMPL_W-1:0] out_lft,
  output logic [SMPL_W-1:0] out_rght,
  output logic              busy,
  output logic              overrun,
  input  logic              ovr_clr
);

  sched_state_t      state_q, state_d;
  logic [SMPL_W-1:0] wrk_l_q, wrk_r_q, pnd_l_q, pnd_r_q;
  logic              pnd_vld_q;
  logic [BAND_W-1:0] band_q;
  logic              chnl_q;
  logic              ovr_q, out_vld_q;
  logic [SMPL_W-1:0] out_l_q, out_r_q;
  logic [SMPL_W-1:0] sat_l, sat_r;

  logic idle_or_done, pnd_pop, smpl_take, load, res_take, last_job, frame_end;
  logic smpl_push, smpl_drop;

  // A new frame may start only from IDLE or DONE; pending always goes first.
  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
  assign pnd_pop      = idle_or_done && pnd_vld_q;
  assign smpl_take    = idle_or_done && !pnd_vld_q && smpl_vld;
  assign load         = pnd_pop || smpl_take;
  assign res_take     = (state_q == WAIT) && res_vld;
  assign last_job     = (band_q == BAND_W'(NUM_BANDS-1)) && chnl_q;
  assign frame_end    = res_take && last_job;
  // An unconsumed sample lands in pending if the slot is free or being
  // emptied this cycle; otherwise it is lost.
  assign smpl_push    = smpl_vld && !smpl_take && (!pnd_vld_q || pnd_pop);
  assign smpl_drop    = smpl_vld && !smpl_take && pnd_vld_q && !pnd_pop;

  // Next-state logic for the job sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: state_d = load ? ISSUE : IDLE;
      ISSUE:      if (job_ack) state_d = WAIT;
      WAIT:       if (res_vld) state_d = last_job ? DONE : ISSUE;
      default:    state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Working sample and (band, channel) step counter; channel toggles first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrk_l_q <= '0;
      wrk_r_q <= '0;
      band_q  <= '0;
      chnl_q  <= 1'b0;
    end else if (load) begin
      wrk_l_q <= pnd_pop ? pnd_l_q : smpl_lft;
      wrk_r_q <= pnd_pop ? pnd_r_q : smpl_rght;
      band_q  <= '0;
      chnl_q  <= 1'b0;
    end else if (res_take) begin
      chnl_q <= ~chnl_q;
      if (chnl_q) band_q <= band_q + 1'b1;
    end
  end

  // One-deep pending buffer and sticky overrun flag (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pnd_vld_q <= 1'b0;
      pnd_l_q   <= '0;
      pnd_r_q   <= '0;
      ovr_q     <= 1'b0;
    end else begin
      pnd_vld_q <= (pnd_vld_q && !pnd_pop) || smpl_push;
      if (smpl_push) begin
        pnd_l_q <= smpl_lft;
        pnd_r_q <= smpl_rght;
      end
      if (smpl_drop)    ovr_q <= 1'b1;
      else if (ovr_clr) ovr_q <= 1'b0;
    end
  end

  // Output capture on the last result so out_vld lands in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_l_q   <= '0;
      out_r_q   <= '0;
    end else begin
      out_vld_q <= frame_end;
      if (frame_end) begin
        out_l_q <= sat_l;
        out_r_q <= sat_r;
      end
    end
  end

  eq_sat_acc u_acc_l (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (load),
    .add_i (res_take && !chnl_q),
    .din_i (res_data),
    .sat_o (sat_l)
  );

  eq_sat_acc u_acc_r (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (load),
    .add_i (res_take && chnl_q),
    .din_i (res_data),
    .sat_o (sat_r)
  );

  assign job_req  = (state_q == ISSUE);
  assign job_band = band_q;
  assign job_chnl = chnl_q;
  assign job_smpl = chnl_q ? wrk_r_q : wrk_l_q;
  assign out_vld  = out_vld_q;
  assign out_lft  = out_l_q;
  assign out_rght = out_r_q;
  assign busy     = (state_q != IDLE);
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_eq_band_sched.sv
// Self-checking bench: an engine model answers jobs, a scoreboard predicts
// each output frame as the clamped per-channel sum of the results returned.
module tb_eq_band_sched;

  localparam int NB = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        smpl_vld = 1'b0;
  logic [23:0] smpl_lft = '0, smpl_rght = '0;
  logic        job_req, job_chnl;
  logic        job_ack = 1'b0;
  logic [2:0]  job_band;
  logic [23:0] job_smpl;
  logic        res_vld = 1'b0;
  logic [23:0] res_data = '0;
  logic        out_vld, busy, overrun;
  logic [23:0] out_lft, out_rght;
  logic        ovr_clr = 1'b0;

  always #5 clk = ~clk;

  eq_band_sched #(.NUM_BANDS(NB), .BAND_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld), .smpl_lft(smpl_lft),
    .smpl_rght(smpl_rght), .job_req(job_req), .job_ack(job_ack),
    .job_band(job_band), .job_chnl(job_chnl), .job_smpl(job_smpl),
    .res_vld(res_vld), .res_data(res_data), .out_vld(out_vld),
    .out_lft(out_lft), .out_rght(out_rght), .busy(busy),
    .overrun(overrun), .ovr_clr(ovr_clr)
  );

  typedef struct { logic [23:0] l; logic [23:0] r; } pair_t;

  int          n_vec = 0, n_err = 0;
  int          ack_dly = 0, res_dly = 1, res_mode = 0;
  logic [23:0] res_const = 24'd100;
  bit          spur_en = 1'b0;
  pair_t       smpl_q[$], exp_q[$];
  int          job_k = 0, job_cnt = 0, out_cnt = 0;
  longint      sum_l = 0, sum_r = 0;

  function automatic logic [23:0] clamp(input longint v);
    if (v > 64'sd8388607)  return 24'h7FFFFF;
    if (v < -64'sd8388608) return 24'h800000;
    return 24'(v);
  endfunction

  // Engine model: checks job order/fields, answers with results, tracks sums.
  initial begin : engine
    int st, cnt;
    logic [2:0]  cb;
    logic        cc;
    logic [23:0] cs, r, es;
    pair_t       p, e;
    st = 0; cnt = 0;
    forever begin
      @(negedge clk);
      job_ack = 1'b0;
      res_vld = 1'b0;
      if (!rst_n) st = 0;
      else if (st == 0) begin
        if (job_req) begin
          n_vec++;
          if (smpl_q.size() == 0) begin
            n_err++;
            $display("FAIL job_nosample: job_req seen with no sample outstanding");
          end else begin
            p  = smpl_q[0];
            es = (job_k % 2) ? p.r : p.l;
            if (job_band !== 3'(job_k / 2) || job_chnl !== 1'(job_k % 2) || job_smpl !== es) begin
              n_err++;
              $display("FAIL job_fields: got b=%0d c=%0d s=%h, want b=%0d c=%0d s=%h",
                       job_band, job_chnl, job_smpl, job_k / 2, job_k % 2, es);
            end
          end
          cb = job_band; cc = job_chnl; cs = job_smpl;
          cnt = ack_dly;
          if (cnt == 0) begin job_ack = 1'b1; job_cnt++; st = 2; cnt = res_dly; end
          else st = 1;
        end else if (spur_en) begin
          res_vld = 1'b1; res_data = 24'($urandom);
        end
      end else if (st == 1) begin
        n_vec++;
        if (job_req !== 1'b1 || job_band !== cb || job_chnl !== cc || job_smpl !== cs) begin
          n_err++;
          $display("FAIL job_hold: got req=%b b=%0d c=%0d s=%h, want req=1 b=%0d c=%0d s=%h",
                   job_req, job_band, job_chnl, job_smpl, cb, cc, cs);
        end
        if (spur_en) begin res_vld = 1'b1; res_data = 24'($urandom); end
        cnt--;
        if (cnt == 0) begin job_ack = 1'b1; job_cnt++; st = 2; cnt = res_dly; end
      end else begin
        cnt--;
        if (cnt == 0) begin
          r = (res_mode == 0) ? res_const : 24'($urandom);
          res_vld = 1'b1; res_data = r;
          if (job_k % 2) sum_r += longint'($signed(r));
          else           sum_l += longint'($signed(r));
          job_k++;
          if (job_k == 2 * NB) begin
            e.l = clamp(sum_l); e.r = clamp(sum_r);
            exp_q.push_back(e);
            if (smpl_q.size() > 0) void'(smpl_q.pop_front());
            job_k = 0; sum_l = 0; sum_r = 0;
          end
          st = 0;
        end else if (spur_en) job_ack = 1'b1;
      end
    end
  end

  // Output monitor: every out_vld must match the next predicted frame.
  initial begin : monitor
    pair_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_vld) begin
        out_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL out_unexpected: out_vld with l=%h r=%h, want no output", out_lft, out_rght);
        end else begin
          e = exp_q.pop_front();
          if (out_lft !== e.l || out_rght !== e.r) begin
            n_err++;
            $display("FAIL out_value: got l=%h r=%h, want l=%h r=%h", out_lft, out_rght, e.l, e.r);
          end
        end
      end
    end
  end

  task automatic send(input logic [23:0] l, input logic [23:0] r, input bit push);
    pair_t p;
    p.l = l; p.r = r;
    if (push) smpl_q.push_back(p);
    smpl_vld = 1'b1; smpl_lft = l; smpl_rght = r;
    @(negedge clk);
    smpl_vld = 1'b0;
  endtask

  task automatic wait_out(input int target, input int budget);
    int c = 0;
    while (out_cnt < target && c < budget) begin @(negedge clk); #1; c++; end
    n_vec++;
    if (out_cnt < target) begin
      n_err++;
      $display("FAIL out_timeout: got %0d outputs, want %0d", out_cnt, target);
    end
  endtask

  task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_job_req", 24'(job_req), 24'd0);
    chk("rst_out_vld", 24'(out_vld), 24'd0);
    chk("rst_busy",    24'(busy),    24'd0);
    chk("rst_overrun", 24'(overrun), 24'd0);
    chk("rst_out_lft", out_lft, 24'd0);
    chk("rst_out_rght", out_rght, 24'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int jc0, oc0;
    time t0;
    ack_dly = 0; res_dly = 1; res_mode = 0; res_const = 24'd100;
    jc0 = job_cnt; oc0 = out_cnt;
    @(negedge clk);
    t0 = $time;
    send(24'($urandom), 24'($urandom), 1'b1);
    wait_out(oc0 + 1, 200);
    chk("single_frame_len", 24'(($time - 1 - t0) / 10 + 1), 24'(2 + 4 * NB));
    chk("single_lft", out_lft, 24'd500);
    chk("single_rght", out_rght, 24'd500);
    repeat (5) @(negedge clk);
    chk("single_jobs", 24'(job_cnt - jc0), 24'(2 * NB));
    chk("single_outs", 24'(out_cnt - oc0), 24'd1);
    chk("single_idle", 24'(busy), 24'd0);
  endtask

  task automatic test_saturation();
    res_mode = 0;
    res_const = 24'h7FFFFF;
    @(negedge clk);
    send(24'h123456, 24'h654321, 1'b1);
    wait_out(out_cnt + 1, 200);
    chk("sat_hi_lft", out_lft, 24'h7FFFFF);
    chk("sat_hi_rght", out_rght, 24'h7FFFFF);
    res_const = 24'h800000;
    @(negedge clk);
    send(24'h0000FF, 24'hFFFF00, 1'b1);
    wait_out(out_cnt + 1, 200);
    chk("sat_lo_lft", out_lft, 24'h800000);
    chk("sat_lo_rght", out_rght, 24'h800000);
  endtask

  task automatic test_back_pressure();
    ack_dly = 3; res_dly = 4; res_mode = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      send(24'($urandom), 24'($urandom), 1'b1);
      wait_out(out_cnt + 1, 400);
    end
    ack_dly = 0; res_dly = 1;
  endtask

  task automatic test_back_to_back();
    int c = 0;
    int oc0;
    ack_dly = 0; res_dly = 1; res_mode = 1;
    oc0 = out_cnt;
    @(negedge clk);
    send(24'($urandom), 24'($urandom), 1'b1);
    while (!out_vld && c < 200) begin @(negedge clk); c++; end
    // Drive the next sample in the DONE cycle itself.
    send(24'($urandom), 24'($urandom), 1'b1);
    chk("b2b_busy", 24'(busy), 24'd1);
    wait_out(oc0 + 2, 200);
    chk("b2b_overrun", 24'(overrun), 24'd0);
  endtask

  task automatic test_overrun();
    int oc0;
    ack_dly = 0; res_dly = 1; res_mode = 1;
    oc0 = out_cnt;
    @(negedge clk);
    send(24'($urandom), 24'($urandom), 1'b1);
    repeat (3) @(negedge clk);
    send(24'($urandom), 24'($urandom), 1'b1);
    repeat (3) @(negedge clk);
    chk("ovr_before", 24'(overrun), 24'd0);
    send(24'($urandom), 24'($urandom), 1'b0);
    chk("ovr_set", 24'(overrun), 24'd1);
    wait_out(oc0 + 2, 400);
    repeat (30) @(negedge clk);
    chk("ovr_outs", 24'(out_cnt - oc0), 24'd2);
    chk("ovr_sticky", 24'(overrun), 24'd1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("ovr_clr", 24'(overrun), 24'd0);
  endtask

  task automatic test_spurious();
    ack_dly = 2; res_dly = 2; res_mode = 1;
    spur_en = 1'b1;
    repeat (4) @(negedge clk);
    send(24'($urandom), 24'($urandom), 1'b1);
    wait_out(out_cnt + 1, 400);
    spur_en = 1'b0;
    ack_dly = 0; res_dly = 1;
  endtask

  task automatic test_reset_mid();
    int c = 0;
    int base, oc0;
    ack_dly = 0; res_dly = 1; res_mode = 1;
    base = job_cnt; oc0 = out_cnt;
    @(negedge clk);
    send(24'($urandom), 24'($urandom), 1'b1);
    while (job_cnt - base < 6 && c < 200) begin @(negedge clk); c++; end
    rst_n = 1'b0;
    @(negedge clk);
    smpl_q.delete(); exp_q.delete();
    job_k = 0; sum_l = 0; sum_r = 0;
    chk("mid_job_req", 24'(job_req), 24'd0);
    chk("mid_busy", 24'(busy), 24'd0);
    chk("mid_out_vld", 24'(out_vld), 24'd0);
    chk("mid_out_lft", out_lft, 24'd0);
    chk("mid_out_rght", out_rght, 24'd0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("mid_no_out", 24'(out_cnt - oc0), 24'd0);
    send(24'($urandom), 24'($urandom), 1'b1);
    wait_out(oc0 + 1, 200);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      ack_dly = $urandom_range(0, 3);
      res_dly = $urandom_range(1, 3);
      res_mode = 1;
      @(negedge clk);
      send(24'($urandom), 24'($urandom), 1'b1);
      wait_out(out_cnt + 1, 400);
    end
    ack_dly = 0; res_dly = 1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_single();
    test_saturation();
    test_back_pressure();
    test_back_to_back();
    test_overrun();
    test_spurious();
    test_reset_mid();
    test_random();
    repeat (10) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d unreported frames, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
